// File: rtl/conv_sched_param_1.sv
// conv_sched_param_1
// Layer-level sequencer for one convolution stage. After a start request it
// pulses a reset to the weight/feature address generators, then steps them for
// NUM_ONEMULT * W * H output pixels of NUM_ONE_PIXEL_CYCLE cycles each. The
// accumulator is cleared on the first cycle of every pixel, and a result strobe
// follows each pixel's last MAC cycle after the MAC pipeline latency. Issue
// pauses at pixel boundaries while the output buffer is full. At the end of
// the layer the pipeline is drained and a one-cycle done pulse is produced.
module conv_sched_param_1 #(
    parameter int NUM_ONEMULT           = 2,
    parameter int OUT_FEATURE_WIDTH_W   = 2,
    parameter int OUT_FEATURE_WIDTH_H   = 2,
    parameter int NUM_ONE_PIXEL_CYCLE   = 4,
    parameter int PIPE_LATENCY          = 4,
    parameter int NUM_MULTCOMP_BITWIDTH = 2,
    parameter int OUTPIXEL_BITWIDTH     = 4,
    parameter int CYC_BITWIDTH          = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             out_ready,
    output logic                             addr_reset,
    output logic                             addr_enable,
    output logic                             acc_clear,
    output logic                             out_valid,
    output logic [OUTPIXEL_BITWIDTH-1:0]     cur_pixel,
    output logic [NUM_MULTCOMP_BITWIDTH-1:0] cur_multcomp,
    output logic                             busy,
    output logic                             done
);

    // Comparison width: wide enough that neither the counters nor the limit
    // constants lose bits when compared.
    localparam int WIDE_A = (OUTPIXEL_BITWIDTH > CYC_BITWIDTH) ? OUTPIXEL_BITWIDTH : CYC_BITWIDTH;
    localparam int WIDE_B = (WIDE_A > NUM_MULTCOMP_BITWIDTH) ? WIDE_A : NUM_MULTCOMP_BITWIDTH;
    localparam int CMP_W  = WIDE_B + 1;

    localparam int PIX_TOTAL = OUT_FEATURE_WIDTH_W * OUT_FEATURE_WIDTH_H;

    localparam logic [CMP_W-1:0] LAST_CYC   = CMP_W'(NUM_ONE_PIXEL_CYCLE - 1);
    localparam logic [CMP_W-1:0] LAST_PIX   = CMP_W'(PIX_TOTAL - 1);
    localparam logic [CMP_W-1:0] LAST_MC    = CMP_W'(NUM_ONEMULT - 1);
    localparam logic [CMP_W-1:0] LAST_DRAIN = CMP_W'(PIPE_LATENCY - 1);
    localparam logic [CMP_W-1:0] CMP_ZERO   = {CMP_W{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_RUN   = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                           r_state;
    logic [CYC_BITWIDTH-1:0]          r_cyc;
    logic [OUTPIXEL_BITWIDTH-1:0]     r_pix;
    logic [NUM_MULTCOMP_BITWIDTH-1:0] r_mc;
    logic [CYC_BITWIDTH-1:0]          r_drain;
    logic [PIPE_LATENCY-1:0]          r_vpipe;

    logic [CMP_W-1:0] w_cyc_ext;
    logic [CMP_W-1:0] w_pix_ext;
    logic [CMP_W-1:0] w_mc_ext;
    logic [CMP_W-1:0] w_drain_ext;
    logic             w_pix_last;
    logic             w_pix_more;
    logic             w_mc_more;
    logic             w_drain_last;
    logic             w_cyc_zero;
    logic             w_feed;

    assign w_cyc_ext   = CMP_W'(r_cyc);
    assign w_pix_ext   = CMP_W'(r_pix);
    assign w_mc_ext    = CMP_W'(r_mc);
    assign w_drain_ext = CMP_W'(r_drain);

    // Last MAC cycle of the pixel being issued (also the first when N = 1).
    assign w_pix_last   = (w_cyc_ext == LAST_CYC);
    assign w_cyc_zero   = (w_cyc_ext == CMP_ZERO);
    assign w_pix_more   = (w_pix_ext < LAST_PIX);
    assign w_mc_more    = (w_mc_ext < LAST_MC);
    assign w_drain_last = (w_drain_ext == LAST_DRAIN);

    // A pixel's result enters the latency line on its final MAC cycle.
    assign w_feed = (r_state == S_RUN) && w_pix_last;

    assign out_valid    = r_vpipe[PIPE_LATENCY-1];
    assign cur_pixel    = r_pix;
    assign cur_multcomp = r_mc;

    // Layer FSM: state, counters and the registered control outputs, which are
    // loaded with the values belonging to the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cyc       <= '0;
            r_pix       <= '0;
            r_mc        <= '0;
            r_drain     <= '0;
            addr_reset  <= 1'b0;
            addr_enable <= 1'b0;
            acc_clear   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            addr_reset  <= 1'b0;
            addr_enable <= 1'b0;
            acc_clear   <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_CLR;
                        addr_reset <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_CLR: begin
                    r_cyc       <= '0;
                    r_pix       <= '0;
                    r_mc        <= '0;
                    r_state     <= S_RUN;
                    addr_enable <= 1'b1;
                    acc_clear   <= 1'b1;
                end
                S_RUN: begin
                    if (!w_pix_last) begin
                        r_cyc       <= r_cyc + CYC_BITWIDTH'(1);
                        addr_enable <= 1'b1;
                    end else begin
                        r_cyc <= '0;
                        if (w_pix_more || w_mc_more) begin
                            if (w_pix_more) begin
                                r_pix <= r_pix + OUTPIXEL_BITWIDTH'(1);
                            end else begin
                                r_pix <= '0;
                                r_mc  <= r_mc + NUM_MULTCOMP_BITWIDTH'(1);
                            end
                            // Back-pressure is only honoured at a pixel boundary.
                            if (out_ready) begin
                                addr_enable <= 1'b1;
                                acc_clear   <= 1'b1;
                            end else begin
                                r_state <= S_WAIT;
                            end
                        end else begin
                            r_state <= S_DRAIN;
                            r_drain <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (out_ready) begin
                        r_state     <= S_RUN;
                        addr_enable <= 1'b1;
                        acc_clear   <= w_cyc_zero;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_DRAIN: begin
                    if (w_drain_last) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end else begin
                        r_drain <= r_drain + CYC_BITWIDTH'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (PIPE_LATENCY == 1) begin : g_vpipe_one
            // Single-stage result strobe line.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe <= w_feed;
                end
            end
        end else begin : g_vpipe_multi
            // Free-running result strobe line, one stage per cycle of MAC latency.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe <= {r_vpipe[PIPE_LATENCY-2:0], w_feed};
                end
            end
        end
    endgenerate

endmodule
